// File: rtl/chansel_pkg.sv
// chansel_pkg: shared state encoding, default sizes and entry-width helper for the channel select sequencer
//   state_t      controller state, IDLE=0 / ACTIVE=1
//   DEPTH_DEF    default command FIFO depth
//   DWELL_W_DEF  default dwell-count width
//   entry_w()    FIFO entry width {sel, dwell} for a given dwell width
package chansel_pkg;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam int DEPTH_DEF   = 4;
    localparam int DWELL_W_DEF = 8;
    localparam int ENTRY_W_DEF = 2 + DWELL_W_DEF;

    function automatic int entry_w(input int dwell_w);
        return 2 + dwell_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and synchronous flush
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and data (ignored while full)
//   pop, rdata     read request (ignored while empty); rdata shows the head entry
//   flush          empties the FIFO at the next edge, overriding push/pop
//   full, empty    occupancy flags
//   count          number of stored entries
module sync_fifo #(
    parameter int WIDTH = chansel_pkg::ENTRY_W_DEF,
    parameter int DEPTH = chansel_pkg::DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; stale entries are never visible because count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/channel_select_sequencer.sv
// channel_select_sequencer: queues {channel, dwell} commands and presents each channel on a registered sel for its dwell
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    command handshake
//   in_sel, in_dwell      channel index and hold time (0 behaves as 1)
//   abort                 flushes queue and active command at the next edge
//   sel, sel_active       registered channel index for the decoder and its qualifier
//   done                  pulse in the final dwell cycle of each command
//   count                 queued (not yet active) commands
module channel_select_sequencer
    import chansel_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_sel,
    input  logic [DWELL_W-1:0]         in_dwell,
    input  logic                       abort,
    output logic [1:0]                 sel,
    output logic                       sel_active,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int EW = entry_w(DWELL_W);

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 sel_active_q, sel_active_d;
    logic                 done_q, done_d;
    logic [EW-1:0]        head;
    logic [DWELL_W-1:0]   head_dwell;
    logic                 fifo_full, fifo_empty, push, pop, last;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .wdata ({in_sel, in_dwell}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign in_ready   = !fifo_full && !abort;
    assign push       = in_valid && in_ready;
    assign head_dwell = head[DWELL_W-1:0] == '0 ? DWELL_W'(1) : head[DWELL_W-1:0];
    assign last       = state_q == ACTIVE && dwell_q == DWELL_W'(1);
    // Load the next command in IDLE or on the final dwell edge, giving gapless back-to-back commands.
    assign pop        = !abort && !fifo_empty && (state_q == IDLE || last);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        if (abort) begin
            state_d = IDLE;
            sel_d   = 2'b00;
            dwell_d = '0;
        end else if (pop) begin
            state_d = ACTIVE;
            sel_d   = head[EW-1:DWELL_W];
            dwell_d = head_dwell;
        end else if (last) begin
            state_d = IDLE;
            sel_d   = 2'b00;
            dwell_d = '0;
        end else if (state_q == ACTIVE) begin
            dwell_d = dwell_q - DWELL_W'(1);
        end
        // Outputs are registered from the next-state values so they line up with state_q.
        sel_active_d = state_d == ACTIVE;
        done_d       = state_d == ACTIVE && dwell_d == DWELL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 2'b00;
            dwell_q      <= '0;
            sel_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            dwell_q      <= dwell_d;
            sel_active_q <= sel_active_d;
            done_q       <= done_d;
        end
    end

    assign sel        = sel_q;
    assign sel_active = sel_active_q;
    assign done       = done_q;

endmodule
